// File: rtl/switch_allocator_onehot.sv
// switch_allocator_onehot: per-output round-robin switch allocator with wormhole packet locking.
// Optional macro SWITCH_ALLOC_CONFLICT_CNT_EN adds saturating per-output conflict counters.
module switch_allocator_onehot #(
    parameter int N = 5,
    parameter int M = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [0:N-1][0:M-1] i_req,
    input  logic [0:N-1]        i_tail,
    input  logic [0:M-1]        i_en,
    output logic [0:M-1][0:N-1] o_sel,
    output logic [0:N-1]        o_grant
`ifdef SWITCH_ALLOC_CONFLICT_CNT_EN
    ,
    output logic [0:M-1][15:0]  o_conflict_cnt
`endif
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {FREE, LOCKED} state_t;

    state_t              state_q [M];
    state_t              state_d [M];
    logic [W-1:0]        ptr_q   [M];
    logic [W-1:0]        ptr_d   [M];
    logic [W-1:0]        owner_q [M];
    logic [W-1:0]        owner_d [M];
    logic [0:M-1][0:N-1] cand;
    logic [0:M-1][0:N-1] sel;

    // Transpose requests into per-output candidate rows; multi-hot rows count as idle
    always_comb begin
        cand = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < M; i++)
                cand[i][j] = i_req[j][i] & $onehot(i_req[j]);
    end

    // Per-output arbitration: the owner alone while locked, else first candidate from ptr onward
    always_comb begin
        int   g;
        logic hit;
        sel = '0;
        for (int i = 0; i < M; i++) begin
            state_d[i] = state_q[i];
            ptr_d[i]   = ptr_q[i];
            owner_d[i] = owner_q[i];
            g          = int'(owner_q[i]);
            hit        = (state_q[i] == LOCKED) && cand[i][g];
            if (state_q[i] == FREE)
                for (int k = N - 1; k >= 0; k--)
                    if (cand[i][(int'(ptr_q[i]) + k) % N]) begin
                        hit = 1'b1;
                        g   = (int'(ptr_q[i]) + k) % N;
                    end
            if (hit && i_en[i]) begin
                sel[i][g]  = 1'b1;
                state_d[i] = i_tail[g] ? FREE : LOCKED;
                ptr_d[i]   = i_tail[g] ? ((g == N - 1) ? '0 : W'(g + 1)) : ptr_q[i];
                owner_d[i] = i_tail[g] ? owner_q[i] : W'(g);
            end
        end
    end

    // Selects feed the crossbar directly, so they are forced quiet while reset is asserted
    always_comb begin
        o_sel   = reset_n ? sel : '0;
        o_grant = '0;
        for (int i = 0; i < M; i++)
            o_grant = o_grant | o_sel[i];
    end

    // Per-output FSM state, round-robin pointer and packet owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                state_q[i] <= FREE;
                ptr_q[i]   <= '0;
                owner_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

`ifdef SWITCH_ALLOC_CONFLICT_CNT_EN
    logic [0:M-1][15:0] cnt_q;
    logic [0:M-1][15:0] cnt_d;

    // Count enabled cycles that leave at least one valid requester (lock-blocked included) waiting
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < M; i++)
            if (i_en[i] && |(cand[i] & ~sel[i]) && cnt_q[i] != 16'hFFFF)
                cnt_d[i] = cnt_q[i] + 16'd1;
    end

    // Conflict counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_conflict_cnt = cnt_q;
`endif

    // Flag multi-hot request rows, which arbitration silently drops
    for (genvar j = 0; j < N; j++) begin : g_chk
        assert property (@(posedge clk) disable iff (!reset_n) $onehot0(i_req[j]))
            else $warning("input %0d drove a multi-hot request, ignored", j);
    end

endmodule

// File: tb/tb_switch_allocator_onehot.sv
// tb_switch_allocator_onehot: directed vectors with hand-computed selects and grants.
module tb_switch_allocator_onehot;
    localparam int N = 5;
    localparam int M = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [0:N-1][0:M-1] i_req;
    logic [0:N-1]        i_tail;
    logic [0:M-1]        i_en;
    logic [0:M-1][0:N-1] o_sel;
    logic [0:N-1]        o_grant;
`ifdef SWITCH_ALLOC_CONFLICT_CNT_EN
    logic [0:M-1][15:0]  o_conflict_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [0:N-1] fair_exp [3] = '{5'b10000, 5'b00100, 5'b00001};

    always #5 clk = ~clk;

    switch_allocator_onehot #(.N(N), .M(M)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (i_req),
        .i_tail  (i_tail),
        .i_en    (i_en),
        .o_sel   (o_sel),
`ifdef SWITCH_ALLOC_CONFLICT_CNT_EN
        .o_conflict_cnt (o_conflict_cnt),
`endif
        .o_grant (o_grant)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Input j requests output o (o < 0 means idle) with the given tail flag
    task automatic rq(input int j, input int o, input logic t);
        i_req[j] = '0;
        if (o >= 0) i_req[j][o] = 1'b1;
        i_tail[j] = t;
    endtask

    task automatic clr();
        i_req  = '0;
        i_tail = '0;
        i_en   = '1;
    endtask

    // Check one select row and the grant vector mid-cycle, then advance past the next edge
    task automatic cyc(input string tag, input int row, input logic [0:N-1] es, input logic [0:N-1] eg);
        @(negedge clk);
        chk({tag, ".sel"}, 32'(o_sel[row]), 32'(es));
        chk({tag, ".gnt"}, 32'(o_grant), 32'(eg));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rq(0, 0, 1'b1);
        #2;
        chk("rst.sel", 32'(o_sel), 32'd0);
        chk("rst.gnt", 32'(o_grant), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clr();

        // Fairness: inputs 0, 2, 4 single-flit packets to output 1
        rq(0, 1, 1'b1); rq(2, 1, 1'b1); rq(4, 1, 1'b1);
        for (int c = 0; c < 6; c++) cyc($sformatf("fair%0d", c), 1, fair_exp[c % 3], fair_exp[c % 3]);
        clr();
`ifdef SWITCH_ALLOC_CONFLICT_CNT_EN
        @(negedge clk);
        chk("cnt1", 32'(o_conflict_cnt[1]), 32'd6);
        @(posedge clk);
        #1;
`endif

        // Wormhole: input 3 four-flit packet to output 0, input 1 waits
        rq(3, 0, 1'b0);
        cyc("worm1", 0, 5'b00010, 5'b00010);
        rq(1, 0, 1'b1);
        cyc("worm2", 0, 5'b00010, 5'b00010);
        cyc("worm3", 0, 5'b00010, 5'b00010);
        rq(3, 0, 1'b1);
        cyc("worm4", 0, 5'b00010, 5'b00010);
        rq(3, -1, 1'b0);
        cyc("worm5", 0, 5'b01000, 5'b01000);
        clr();

        // Backpressure on flit 2 (ptr[0] is now 2, so input 3 still wins the head)
        rq(3, 0, 1'b0);
        cyc("bp1", 0, 5'b00010, 5'b00010);
        rq(1, 0, 1'b1);
        i_en[0] = 1'b0;
        cyc("bp_stall", 0, 5'b00000, 5'b00000);
        i_en[0] = 1'b1;
        cyc("bp2", 0, 5'b00010, 5'b00010);
        cyc("bp3", 0, 5'b00010, 5'b00010);
        rq(3, 0, 1'b1);
        cyc("bp4", 0, 5'b00010, 5'b00010);
        rq(3, -1, 1'b0);
        cyc("bp5", 0, 5'b01000, 5'b01000);
        clr();

        // Owner gap: locked owner idles two cycles while input 1 requests
        rq(3, 0, 1'b0);
        cyc("gap0", 0, 5'b00010, 5'b00010);
        rq(3, -1, 1'b0);
        rq(1, 0, 1'b1);
        cyc("gap1", 0, 5'b00000, 5'b00000);
        cyc("gap2", 0, 5'b00000, 5'b00000);
        rq(3, 0, 1'b1);
        cyc("gap3", 0, 5'b00010, 5'b00010);
        rq(3, -1, 1'b0);
        cyc("gap4", 0, 5'b01000, 5'b01000);
        clr();

        // Parallel: input j to output j
        for (int j = 0; j < N; j++) rq(j, j, 1'b1);
        cyc("par", 2, 5'b00100, 5'b11111);
        clr();

        // Multi-hot input 2 ignored; ptr[1] is 2 so a live input 2 would beat input 0
        i_req[2] = 5'b01100;
        i_tail[2] = 1'b1;
        rq(0, 1, 1'b1);
        cyc("mh1", 1, 5'b10000, 5'b10000);
        rq(0, -1, 1'b0);
        cyc("mh2", 2, 5'b00000, 5'b00000);
        clr();

        // Reset mid-packet: lock input 2 on output 3, then assert reset between edges
        rq(2, 3, 1'b0);
        cyc("pkt", 3, 5'b00100, 5'b00100);
        rq(0, 3, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst.sel", 32'(o_sel), 32'd0);
        chk("arst.gnt", 32'(o_grant), 32'd0);
`ifdef SWITCH_ALLOC_CONFLICT_CNT_EN
        chk("arst.cnt1", 32'(o_conflict_cnt[1]), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clr();
        rq(0, 3, 1'b1);
        cyc("unlock", 3, 5'b10000, 5'b10000);
        clr();
        rq(1, 2, 1'b1); rq(4, 2, 1'b1);
        cyc("ptr0", 2, 5'b01000, 5'b01000);
        clr();

        // Wrap: move ptr[4] to 4, grant input 4, pointer wraps to 0
        rq(3, 4, 1'b1);
        cyc("wrap1", 4, 5'b00010, 5'b00010);
        rq(3, -1, 1'b0); rq(0, 4, 1'b1); rq(4, 4, 1'b1);
        cyc("wrap2", 4, 5'b00001, 5'b00001);
        rq(4, -1, 1'b0); rq(3, 4, 1'b1);
        cyc("wrap3", 4, 5'b10000, 5'b10000);
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/switch_allocator_onehot.md
Name: switch_allocator_onehot

Overview:
- Per-output round-robin switch allocator with wormhole packet locking.
- Sits directly upstream of the router's onehot packet crossbar. Its o_sel drives the crossbar select input in the same cycle.
- Consumes route-computed output requests from the N input buffers.
- Returns a per-input grant that the input buffers use to pop the current flit.

Parameters:
- N, 5, number of input ports (requesters).
- M, 5, number of output ports (resources).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_req  input  [0:N-1][0:M-1]  per-input onehot output request; all-zero = idle.
- i_tail  input  [0:N-1]  flit at head of input j is a packet tail; a single-flit packet sets it on the head flit.
- i_en  input  [0:M-1]  output i may accept a flit this cycle (downstream credit/space available).
- o_sel  output  [0:M-1][0:N-1]  onehot input select per output; element j of row i set = output i takes input j. Bit ordering: element 0 is the MSB, matching the crossbar's select compare.
- o_grant  output  [0:N-1]  input j's flit is transferred this cycle.

Behaviour:
- Latency: combinational. o_sel and o_grant derive from the current i_req, i_tail, i_en and registered state, all in the same cycle.
- Registered state, per output i:
  - ptr[i]: priority pointer, range 0..N-1.
  - lock[i]: locked flag, 1 bit.
  - owner[i]: owning input index.
- Reset (reset_n low, asynchronous):
  - ptr=0, lock=0, owner=0.
  - o_sel and o_grant are forced all-zero while reset_n is low.
- Request validity:
  - Only onehot i_req[j] rows are considered.
  - A multi-hot row is treated as no request, and a simulation assertion fires.
- Per-output FSM, two states:
  - FREE:
    - Candidates are inputs j with i_req[j][i]=1.
    - If i_en[i]=1 and at least one candidate exists, grant the first candidate at or after ptr[i] in round-robin order (ptr, ptr+1, ..., N-1, 0, ...).
    - If the granted flit is not a tail: go to LOCKED, owner=j, ptr unchanged.
    - If the granted flit is a tail: stay FREE, ptr=(j+1) mod N.
  - LOCKED:
    - Only owner[i] is eligible.
    - A grant requires i_req[owner][i]=1 and i_en[i]=1.
    - Grant with i_tail[owner]=1: go to FREE, ptr=(owner+1) mod N.
    - Grant without tail: stay LOCKED.
    - No grant: all state held. This includes the case where owner drops its request mid-packet; the lock is never broken by other requesters.
- i_en[i]=0: no grant on output i, state unchanged, in either state.
- Output encoding:
  - o_sel[i] is exactly onehot (granted input) or all-zero.
  - o_grant[j] = OR over i of o_sel[i][j].
  - Each input requests at most one output, so at most one grant per input.
- Wrap-around: pointer arithmetic is mod N. ptr=N-1 after a grant to N-1 wraps to 0.
- Simultaneous tail grant and new request: the next packet's head competes in the following cycle under the updated ptr.
- Reset mid-packet clears every lock. Upstream buffers are reset in the same domain, so no partial packet survives.

Optional Feature:
- Macro: SWITCH_ALLOC_CONFLICT_CNT_EN.
- When defined:
  - Adds output port o_conflict_cnt [0:M-1][15:0].
  - Per output, increments by 1 each cycle in which i_en[i]=1 and at least one requester of output i is not granted. This includes requesters blocked by a lock.
  - Saturates at 16'hFFFF.
  - Resets to 0 asynchronously.
- When undefined: the port and counters do not exist; allocation behaviour is identical.

Test Plan:
1. Fairness:
   - Stimulus: N=M=5, inputs 0, 2 and 4 all request output 1 with single-flit packets (tail=1); i_en=all ones for 6 cycles.
   - Required: grants to inputs 0, 2, 4, 0, 2, 4. o_sel[1] = 5'b10000, 5'b00100, 5'b00001, repeating.
2. Wormhole lock:
   - Stimulus: input 3 sends a 4-flit packet to output 0, tail on flit 4. Input 1 requests output 0 continuously.
   - Required: input 3 is granted 4 consecutive cycles; input 1 is granted in cycle 5; ptr[0] is 4 after cycle 4.
3. Backpressure:
   - Stimulus: same as scenario 2, with i_en[0]=0 during flit 2.
   - Required: no grant that cycle, lock held, input 1 still blocked; the packet completes 1 cycle later.
4. Owner gap:
   - Stimulus: locked owner drops its request for 2 cycles mid-packet while another input requests the same output.
   - Required: o_sel row all-zero for those 2 cycles; the lock resumes with the same owner.
5. Parallel and illegal requests:
   - Stimulus: inputs 0 to 4 each request a distinct output in one cycle; then input 2 drives multi-hot 5'b01100.
   - Required: 5 simultaneous grants, o_grant=5'b11111; the multi-hot row is ignored and the assertion fires.
6. Reset and wrap:
   - Stimulus: assert reset_n low mid-packet.
   - Required: outputs 0 immediately, locks cleared, ptr=0. After release, a grant to input 4 wraps ptr to 0.
   - With SWITCH_ALLOC_CONFLICT_CNT_EN defined: scenario 1 yields o_conflict_cnt[1]=6.
